fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/execute datapath.
- Owns the architectural fetch PC and drives the synchronous-read text RAM (1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect (taken branch or jump target) from the next-PC logic and squashes wrong-path words.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, text RAM request, instruction buffer, redirect squash
module fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_en,
    output logic [PC_WIDTH-3:0] imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    input  logic                inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight;

    logic [31:0]         fifo_word [DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    logic                pop;
    logic                push;
    logic                issue;
    logic [CW:0]         credit;
    logic                unused_low_bits;

    // Byte offset of the redirect target is dropped; targets are always word-aligned.
    assign unused_low_bits = ^redirect_pc[1:0];

    assign pop  = inst_valid && inst_ready;
    assign push = inflight && !redirect;

    // Entries already owned (buffered plus outstanding) minus the one leaving this cycle;
    // a new request is only issued when its return is guaranteed a free slot.
    assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue  = rst_n && !redirect && (credit < (CW+1)'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = fetch_pc[PC_WIDTH-1:2];

    assign inst_valid = (count != '0);
    assign inst       = fifo_word[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    // Fetch PC and outstanding-request tracking; redirect restarts fetch one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
        end else if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_WIDTH'(4);
            inflight    <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Instruction buffer: push returning words, pop on decode handshake, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_word[wr_ptr] <= imem_data;
                fifo_pc[wr_ptr]   <= inflight_pc;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

    localparam int PC_WIDTH = 8;
    localparam int DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_ready;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       m_inflight;
    logic [7:0] m_inflight_pc;
    logic [7:0] m_fetch_pc;
    logic [7:0] exp_pc;

    fetch_unit #(.PC_WIDTH(PC_WIDTH), .RESET_PC(8'h00), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text RAM: word[i] = 0x1000_0000 + i, one-cycle read latency
    initial imem_data = '0;
    always @(posedge clk) if (imem_en) imem_data <= 32'h1000_0000 + 32'(imem_addr);

    function automatic logic [31:0] word_of(input logic [7:0] pc);
        return 32'h1000_0000 + 32'(pc[7:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = 8'h00;
        exp_pc        = 8'h00;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model, move to next negedge
    task automatic cycle(input logic rdy, input logic redir, input logic [7:0] rpc);
        logic pop;
        logic en;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        pop = (q.size() > 0) && rdy;
        en  = !redir && ((q.size() + int'(m_inflight) - int'(pop)) < DEPTH);
        chk("inst_valid", 32'(inst_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("head_pc", 32'(inst_pc), 32'(q[0]));
            chk("head_inst", inst, word_of(q[0]));
        end
        chk("imem_en", 32'(imem_en), 32'(en));
        if (en) chk("imem_addr", 32'(imem_addr), 32'(m_fetch_pc[7:2]));
        if (pop) begin
            chk("seq_pc", 32'(inst_pc), 32'(exp_pc));
            chk("seq_inst", inst, word_of(exp_pc));
            exp_pc = exp_pc + 8'd4;
        end
        if (redir) begin
            q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = {rpc[7:2], 2'b00};
            exp_pc     = {rpc[7:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (m_inflight) q.push_back(m_inflight_pc);
            if (en) begin
                m_inflight_pc = m_fetch_pc;
                m_fetch_pc    = m_fetch_pc + 8'd4;
                m_inflight    = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  wrap_exp [4];
        logic [31:0] held_inst;
        logic [7:0]  held_pc;
        wrap_exp = '{8'hF8, 8'hFC, 8'h00, 8'h04};

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        model_reset();

        // Reset values
        #2;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill latency and streaming
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        chk("fill_valid", 32'(inst_valid), 32'd1);
        chk("fill_inst0", inst, 32'h1000_0000);
        chk("fill_pc0", 32'(inst_pc), 32'h00);
        cycle(1'b1, 1'b0, 8'h00);
        chk("fill_inst1", inst, 32'h1000_0001);
        chk("fill_pc1", 32'(inst_pc), 32'h04);
        cycle(1'b1, 1'b0, 8'h00);
        chk("fill_pc2", 32'(inst_pc), 32'h08);

        // Stall: buffer fills, request stops, head held
        held_inst = inst;
        held_pc   = inst_pc;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        #1;
        chk("stall_en", 32'(imem_en), 32'd0);
        chk("stall_inst", inst, held_inst);
        chk("stall_pc", 32'(inst_pc), 32'(held_pc));
        @(negedge clk);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // Redirect to unaligned target, with a pop and in-flight return in the same cycle
        cycle(1'b1, 1'b1, 8'h43);
        chk("redir_gap1", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 8'h00);
        chk("redir_gap2", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 8'h00);
        chk("redir_pc", 32'(inst_pc), 32'h40);
        chk("redir_inst", inst, 32'h1000_0010);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);

        // PC wrap-around
        cycle(1'b1, 1'b1, 8'hF8);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_pc", 32'(inst_pc), 32'(wrap_exp[i]));
            cycle(1'b1, 1'b0, 8'h00);
        end

        // Asynchronous reset mid-stream with the buffer full
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_en", 32'(imem_en), 32'd0);
        chk("arst_inst", inst, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        chk("arst_first_pc", 32'(inst_pc), 32'h00);
        chk("arst_first_inst", inst, 32'h1000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
